// File: rtl/coherence_bus_arbiter.sv
// ---------------------------------------------------------------------------
// coherence_bus_arbiter
//   Round-robin sequencer for the shared snooping-coherence bus and the
//   unified-memory port between NCPU cpu instances. One transaction at a time:
//   grant the winner, broadcast its tag to the other caches, take the line
//   from a peer cache or from unified memory, invalidate the other copies
//   where the op requires it, then pulse completion to the owner.
//
//   Optional build macro: BUS_TIMEOUT_EN (MEM wait watchdog, drives bus_err).
//
// Ports:
//   clk                        system clock
//   rst                        synchronous active-high reset
//   read_miss/write_miss/
//   invalidate      [NCPU]     per-CPU requests (inv > write > read)
//   BICO            [NCPU*TAG_W] per-CPU line address, CPU i at [i*TAG_W +: TAG_W]
//   cpu_search_found[NCPU]     snoop hit from each cache
//   u_rdy                      unified memory operation finished
//   grant           [NCPU]     one-hot bus ownership, GRANT..DONE
//   cpu_search      [NCPU]     snoop strobe to non-owners (SNOOP)
//   BOCI            [TAG_W+2]  {op, tag}; op 01 read, 10 write, 11 inv
//   cpu_datasel     [2*NCPU]   per-CPU data source: 01 peer, 10 memory
//   invalidate_from_other_cpu  invalidate strobe to non-owners (INV)
//   u_sel           [2]        CPU index owning the memory port (MEM)
//   u_go                       unified memory access in progress (MEM)
//   xfer_done       [NCPU]     one-cycle completion pulse to owner (DONE)
//   bus_err                    sticky MEM timeout flag (0 without macro)
// ---------------------------------------------------------------------------
module coherence_bus_arbiter #(
  parameter int unsigned NCPU  = 2,
  parameter int unsigned TAG_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCPU-1:0]       read_miss,
  input  logic [NCPU-1:0]       write_miss,
  input  logic [NCPU-1:0]       invalidate,
  input  logic [NCPU*TAG_W-1:0] BICO,
  input  logic [NCPU-1:0]       cpu_search_found,
  input  logic                  u_rdy,
  output logic [NCPU-1:0]       grant,
  output logic [NCPU-1:0]       cpu_search,
  output logic [TAG_W+1:0]      BOCI,
  output logic [2*NCPU-1:0]     cpu_datasel,
  output logic [NCPU-1:0]       invalidate_from_other_cpu,
  output logic [1:0]            u_sel,
  output logic                  u_go,
  output logic [NCPU-1:0]       xfer_done,
  output logic                  bus_err
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_GRANT = 3'd1;
  localparam logic [ST_W-1:0] S_SNOOP = 3'd2;
  localparam logic [ST_W-1:0] S_SWAIT = 3'd3;
  localparam logic [ST_W-1:0] S_CXFER = 3'd4;
  localparam logic [ST_W-1:0] S_MEM   = 3'd5;
  localparam logic [ST_W-1:0] S_INV   = 3'd6;
  localparam logic [ST_W-1:0] S_DONE  = 3'd7;

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam logic [NCPU-1:0]   ONE_HOT0 = NCPU'(1);
  localparam logic [2*NCPU-1:0] DS_PEER  = (2*NCPU)'(2'b01);
  localparam logic [2*NCPU-1:0] DS_MEM   = (2*NCPU)'(2'b10);

  // FSM and transaction context
  logic [ST_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  w_q, w_d;
  logic [1:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  // Registered outputs
  logic [NCPU-1:0]   grant_q, grant_d;
  logic [NCPU-1:0]   search_q, search_d;
  logic [TAG_W+1:0]  boci_q, boci_d;
  logic [2*NCPU-1:0] datasel_q, datasel_d;
  logic [NCPU-1:0]   inv_q, inv_d;
  logic [1:0]        u_sel_q, u_sel_d;
  logic              u_go_q, u_go_d;
  logic [NCPU-1:0]   done_q, done_d;

  // Arbitration helpers
  logic [NCPU-1:0]   req;
  logic              req_found;
  logic [IDX_W-1:0]  win;
  logic [1:0]        win_op;
  logic [TAG_W-1:0]  win_tag;
  logic [NCPU-1:0]   own_oh;
  logic [NCPU-1:0]   next_oh;
  logic              peer_hit;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'd254;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      w_q       <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      grant_q   <= '0;
      search_q  <= '0;
      boci_q    <= '0;
      datasel_q <= '0;
      inv_q     <= '0;
      u_sel_q   <= '0;
      u_go_q    <= 1'b0;
      done_q    <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      w_q       <= w_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      grant_q   <= grant_d;
      search_q  <= search_d;
      boci_q    <= boci_d;
      datasel_q <= datasel_d;
      inv_q     <= inv_d;
      u_sel_q   <= u_sel_d;
      u_go_q    <= u_go_d;
      done_q    <= done_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next state, context capture and next-output decode
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    w_d       = w_q;
    op_d      = op_q;
    tag_d     = tag_q;
    req       = read_miss | write_miss | invalidate;
    req_found = 1'b0;
    win       = rr_q;
    win_op    = OP_RD;
    win_tag   = '0;
    own_oh    = ONE_HOT0 << w_q;
    peer_hit  = |(cpu_search_found & ~own_oh);
`ifdef BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    // First requester at or after rr_q, wrapping modulo NCPU
    for (int unsigned k = 0; k < NCPU; k++) begin
      int unsigned idx;
      idx = 32'(rr_q) + k;
      if (idx >= NCPU) idx = idx - NCPU;
      if (!req_found && req[idx]) begin
        req_found = 1'b1;
        win       = IDX_W'(idx);
      end
    end

    for (int unsigned i = 0; i < NCPU; i++) begin
      if (IDX_W'(i) == win) begin
        win_tag = BICO[i*TAG_W +: TAG_W];
        if (invalidate[i])      win_op = OP_INV;
        else if (write_miss[i]) win_op = OP_WR;
        else                    win_op = OP_RD;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          w_d     = win;
          op_d    = win_op;
          tag_d   = win_tag;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_SNOOP;
      S_SNOOP: state_d = (op_q == OP_INV) ? S_INV : S_SWAIT;
      S_SWAIT: state_d = peer_hit ? S_CXFER : S_MEM;
      S_CXFER: state_d = (op_q == OP_WR) ? S_INV : S_DONE;
      S_MEM: begin
        if (u_rdy) begin
          state_d = (op_q == OP_WR) ? S_INV : S_DONE;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          // 255th MEM cycle without u_rdy: abandon the access
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      S_INV: state_d = S_DONE;
      S_DONE: begin
        rr_d    = (32'(w_q) == NCPU - 1) ? '0 : w_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BUS_TIMEOUT_EN
    if (state_q != S_MEM && state_d == S_MEM) cnt_d = '0;
`endif

    // Outputs registered alongside the state they belong to
    next_oh   = ONE_HOT0 << w_d;
    grant_d   = (state_d != S_IDLE) ? next_oh : '0;
    boci_d    = (state_d != S_IDLE) ? {op_d, tag_d} : '0;
    search_d  = (state_d == S_SNOOP) ? ~next_oh : '0;
    inv_d     = (state_d == S_INV) ? ~next_oh : '0;
    done_d    = (state_d == S_DONE) ? next_oh : '0;
    u_go_d    = (state_d == S_MEM);
    u_sel_d   = (state_d == S_MEM) ? w_d : '0;
    datasel_d = '0;
    if (state_d == S_CXFER)    datasel_d = DS_PEER << {w_d, 1'b0};
    else if (state_d == S_MEM) datasel_d = DS_MEM << {w_d, 1'b0};
  end

  assign grant                     = grant_q;
  assign cpu_search                = search_q;
  assign BOCI                      = boci_q;
  assign cpu_datasel               = datasel_q;
  assign invalidate_from_other_cpu = inv_q;
  assign u_sel                     = u_sel_q;
  assign u_go                      = u_go_q;
  assign xfer_done                 = done_q;
`ifdef BUS_TIMEOUT_EN
  assign bus_err                   = err_q;
`else
  assign bus_err                   = 1'b0;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_arbiter
//   Directed bench for coherence_bus_arbiter (NCPU=2, TAG_W=11). Inputs are
//   driven and outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_coherence_bus_arbiter;

  localparam int unsigned NCPU  = 2;
  localparam int unsigned TAG_W = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCPU-1:0]       read_miss;
  logic [NCPU-1:0]       write_miss;
  logic [NCPU-1:0]       invalidate;
  logic [NCPU*TAG_W-1:0] BICO;
  logic [NCPU-1:0]       cpu_search_found;
  logic                  u_rdy;
  logic [NCPU-1:0]       grant;
  logic [NCPU-1:0]       cpu_search;
  logic [TAG_W+1:0]      BOCI;
  logic [2*NCPU-1:0]     cpu_datasel;
  logic [NCPU-1:0]       invalidate_from_other_cpu;
  logic [1:0]            u_sel;
  logic                  u_go;
  logic [NCPU-1:0]       xfer_done;
  logic                  bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coherence_bus_arbiter #(.NCPU(NCPU), .TAG_W(TAG_W)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .BICO                      (BICO),
    .cpu_search_found          (cpu_search_found),
    .u_rdy                     (u_rdy),
    .grant                     (grant),
    .cpu_search                (cpu_search),
    .BOCI                      (BOCI),
    .cpu_datasel               (cpu_datasel),
    .invalidate_from_other_cpu (invalidate_from_other_cpu),
    .u_sel                     (u_sel),
    .u_go                      (u_go),
    .xfer_done                 (xfer_done),
    .bus_err                   (bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NCPU-1:0] exp_own;
    int n;

    rst = 1'b1; read_miss = '0; write_miss = '0; invalidate = '0;
    BICO = '0; cpu_search_found = '0; u_rdy = 1'b0;
    step(); step();

    // Reset state
    chk("rst grant",   32'(grant), 32'h0);
    chk("rst search",  32'(cpu_search), 32'h0);
    chk("rst boci",    32'(BOCI), 32'h0);
    chk("rst datasel", 32'(cpu_datasel), 32'h0);
    chk("rst inv",     32'(invalidate_from_other_cpu), 32'h0);
    chk("rst u_sel",   32'(u_sel), 32'h0);
    chk("rst u_go",    32'(u_go), 32'h0);
    chk("rst done",    32'(xfer_done), 32'h0);
    chk("rst bus_err", 32'(bus_err), 32'h0);
    rst = 1'b0;
    step();
    chk("idle grant", 32'(grant), 32'h0);

    // Read miss on CPU0, CPU1 holds the line
    read_miss = 2'b01; BICO = {11'h000, 11'h155};
    step(); // GRANT
    chk("A grant",  32'(grant), 32'h1);
    chk("A boci",   32'(BOCI), 32'h0955);
    chk("A search in grant", 32'(cpu_search), 32'h0);
    cpu_search_found = 2'b10;
    step(); // SNOOP
    chk("A search", 32'(cpu_search), 32'h2);
    step(); // SWAIT
    chk("A search off", 32'(cpu_search), 32'h0);
    step(); // CXFER
    cpu_search_found = '0;
    chk("A datasel", 32'(cpu_datasel), 32'h1);
    chk("A done early", 32'(xfer_done), 32'h0);
    step(); // DONE
    chk("A datasel off", 32'(cpu_datasel), 32'h0);
    chk("A done", 32'(xfer_done), 32'h1);
    chk("A grant held", 32'(grant), 32'h1);
    read_miss = '0;
    step(); // IDLE
    chk("A grant drop", 32'(grant), 32'h0);
    chk("A done drop", 32'(xfer_done), 32'h0);
    chk("A boci drop", 32'(BOCI), 32'h0);

    // Write miss on CPU1 from memory; owner's own snoop hit is masked
    write_miss = 2'b10; BICO = {11'h020, 11'h000}; cpu_search_found = 2'b10;
    step(); // GRANT
    chk("B grant", 32'(grant), 32'h2);
    chk("B boci",  32'(BOCI), 32'h1020);
    step(); // SNOOP
    chk("B search", 32'(cpu_search), 32'h1);
    BICO = {11'h3AA, 11'h000};
    step(); // SWAIT
    step(); // MEM 1
    chk("B u_go1",  32'(u_go), 32'h1);
    chk("B u_sel",  32'(u_sel), 32'h1);
    chk("B datasel", 32'(cpu_datasel), 32'h8);
    chk("B boci latched", 32'(BOCI), 32'h1020);
    step(); // MEM 2
    chk("B u_go2", 32'(u_go), 32'h1);
    step(); // MEM 3
    chk("B u_go3", 32'(u_go), 32'h1);
    u_rdy = 1'b1;
    step(); // INV
    u_rdy = 1'b0; cpu_search_found = '0;
    chk("B u_go off", 32'(u_go), 32'h0);
    chk("B inv", 32'(invalidate_from_other_cpu), 32'h1);
    chk("B datasel off", 32'(cpu_datasel), 32'h0);
    step(); // DONE
    chk("B done", 32'(xfer_done), 32'h2);
    chk("B inv off", 32'(invalidate_from_other_cpu), 32'h0);
    write_miss = '0;
    step(); // IDLE

    // Invalidate plus read miss on CPU0: invalidate wins
    invalidate = 2'b01; read_miss = 2'b01; BICO = {11'h000, 11'h7FF};
    step(); // GRANT
    chk("C boci", 32'(BOCI), 32'h1FFF);
    chk("C grant", 32'(grant), 32'h1);
    step(); // SNOOP
    chk("C search", 32'(cpu_search), 32'h2);
    chk("C u_go snoop", 32'(u_go), 32'h0);
    step(); // INV
    chk("C inv", 32'(invalidate_from_other_cpu), 32'h2);
    chk("C datasel", 32'(cpu_datasel), 32'h0);
    chk("C u_go inv", 32'(u_go), 32'h0);
    step(); // DONE
    chk("C done", 32'(xfer_done), 32'h1);
    invalidate = '0; read_miss = '0;
    step(); // IDLE, round-robin pointer now 1

    // Reset for two cycles while in MEM
    read_miss = 2'b01;
    n = 0;
    while (u_go !== 1'b1 && n < 10) begin step(); n++; end
    chk("R reached MEM", 32'(u_go), 32'h1);
    rst = 1'b1;
    step();
    chk("R grant",   32'(grant), 32'h0);
    chk("R u_go",    32'(u_go), 32'h0);
    chk("R done",    32'(xfer_done), 32'h0);
    chk("R datasel", 32'(cpu_datasel), 32'h0);
    step();
    rst = 1'b0; read_miss = '0;
    chk("R boci",  32'(BOCI), 32'h0);
    chk("R u_sel", 32'(u_sel), 32'h0);
    step();
    chk("R no done", 32'(xfer_done), 32'h0);
    chk("R idle grant", 32'(grant), 32'h0);

    // Round-robin: both CPUs request continuously, memory ready at once
    read_miss = 2'b11; u_rdy = 1'b1;
    exp_own = 2'b01;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (grant === '0 && n < 20) begin step(); n++; end
      chk($sformatf("RR grant %0d", t), 32'(grant), 32'(exp_own));
      n = 0;
      while (xfer_done === '0 && n < 20) begin step(); n++; end
      chk($sformatf("RR done %0d", t), 32'(xfer_done), 32'(exp_own));
      step();
      exp_own = ~exp_own;
    end
    read_miss = '0; u_rdy = 1'b0;
    step(); step();

`ifdef BUS_TIMEOUT_EN
    // Memory never answers: watchdog abandons after 255 MEM cycles
    read_miss = 2'b01;
    n = 0;
    while (u_go !== 1'b1 && n < 10) begin step(); n++; end
    chk("T reached MEM", 32'(u_go), 32'h1);
    chk("T no err yet", 32'(bus_err), 32'h0);
    n = 0;
    while (u_go === 1'b1 && n < 400) begin step(); n++; end
    chk("T mem cycles", 32'(n), 32'd255);
    chk("T done", 32'(xfer_done), 32'h1);
    chk("T bus_err", 32'(bus_err), 32'h1);
    chk("T datasel", 32'(cpu_datasel), 32'h0);
    read_miss = '0;
    step(); step();
    chk("T err sticky", 32'(bus_err), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("T err cleared", 32'(bus_err), 32'h0);
`else
    // Memory stalls a long time: arbiter keeps waiting, no error
    read_miss = 2'b01;
    n = 0;
    while (u_go !== 1'b1 && n < 10) begin step(); n++; end
    chk("W reached MEM", 32'(u_go), 32'h1);
    repeat (300) step();
    chk("W still MEM", 32'(u_go), 32'h1);
    chk("W no bus_err", 32'(bus_err), 32'h0);
    u_rdy = 1'b1;
    step();
    u_rdy = 1'b0;
    chk("W done", 32'(xfer_done), 32'h1);
    read_miss = '0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
